// File: rtl/alu_exec_unit.sv
// Execute stage: AND/OR/ADD/SUB in one cycle, MUL by iterative shift-add over WIDTH cycles.
// Latency 1 cycle (WIDTH+1 for MUL); results held in DONE until out_ready, no accept while busy.
module alu_exec_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       alu_ctrl,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             ovf,
  output logic             illegal
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [3:0] C_AND = 4'b0000;
  localparam logic [3:0] C_OR  = 4'b0001;
  localparam logic [3:0] C_ADD = 4'b0010;
  localparam logic [3:0] C_SUB = 4'b0011;
  localparam logic [3:0] C_MUL = 4'b0100;

  logic [1:0]       state;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] acc;
  logic [CW-1:0]    cnt;

  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic             ovf_add;
  logic             ovf_sub;
  logic [WIDTH-1:0] acc_nxt;
  logic [WIDTH-1:0] alu_res;
  logic             alu_ovf;

  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_DONE);

  assign sum     = op_a + op_b;
  assign diff    = op_a - op_b;
  assign ovf_add = (op_a[WIDTH-1] == op_b[WIDTH-1]) && (sum[WIDTH-1]  != op_a[WIDTH-1]);
  assign ovf_sub = (op_a[WIDTH-1] != op_b[WIDTH-1]) && (diff[WIDTH-1] != op_a[WIDTH-1]);
  assign acc_nxt = mplier[0] ? (acc + mcand) : acc;

  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    case (alu_ctrl)
      C_AND: alu_res = op_a & op_b;
      C_OR:  alu_res = op_a | op_b;
      C_ADD: begin
        alu_res = sum;
        alu_ovf = ovf_add;
      end
      C_SUB: begin
        alu_res = diff;
        alu_ovf = ovf_sub;
      end
      default: begin
        alu_res = '0;
        alu_ovf = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      mcand   <= '0;
      mplier  <= '0;
      acc     <= '0;
      cnt     <= '0;
      result  <= '0;
      zero    <= 1'b0;
      ovf     <= 1'b0;
      illegal <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            if (alu_ctrl == C_MUL) begin
              mcand  <= op_a;
              mplier <= op_b;
              acc    <= '0;
              cnt    <= '0;
              state  <= S_MUL;
            end else if (alu_ctrl > C_MUL) begin
              result  <= '0;
              zero    <= 1'b1;
              ovf     <= 1'b0;
              illegal <= 1'b1;
              state   <= S_DONE;
            end else begin
              result  <= alu_res;
              zero    <= (alu_res == '0);
              ovf     <= alu_ovf;
              illegal <= 1'b0;
              state   <= S_DONE;
            end
          end
        end
        S_MUL: begin
          // The last of WIDTH steps writes its partial sum straight into result.
          acc    <= acc_nxt;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          if (cnt == CW'(WIDTH - 1)) begin
            result  <= acc_nxt;
            zero    <= (acc_nxt == '0);
            ovf     <= 1'b0;
            illegal <= 1'b0;
            cnt     <= '0;
            state   <= S_DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DONE: begin
          if (out_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Randomized scoreboard bench for alu_exec_unit against an arithmetic reference model.
module tb_alu_exec_unit;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [3:0]   alu_ctrl = 4'd0;
  logic [W-1:0] op_a = '0;
  logic [W-1:0] op_b = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] result;
  logic         zero;
  logic         ovf;
  logic         illegal;

  typedef struct {
    logic [W-1:0] res;
    logic         zero;
    logic         ovf;
    logic         ill;
    int           lat;
    int           acc_cyc;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  bit   rand_rdy = 1'b1;
  bit   mon_seen = 1'b0;

  alu_exec_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .alu_ctrl(alu_ctrl), .op_a(op_a), .op_b(op_b), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .zero(zero), .ovf(ovf), .illegal(illegal)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #2;
    if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
  end

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic exp_t model(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    longint sa, sb, sr;
    logic [63:0] prod;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    e.ovf = 1'b0;
    e.ill = 1'b0;
    e.lat = 1;
    e.acc_cyc = 0;
    case (c)
      4'd0: e.res = a & b;
      4'd1: e.res = a | b;
      4'd2: begin
        sr = sa + sb;
        e.res = W'(sr);
        e.ovf = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
      end
      4'd3: begin
        sr = sa - sb;
        e.res = W'(sr);
        e.ovf = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
      end
      4'd4: begin
        prod = {32'd0, a} * {32'd0, b};
        e.res = prod[W-1:0];
        e.lat = W + 1;
      end
      default: begin
        e.res = '0;
        e.ill = 1'b1;
      end
    endcase
    e.zero = (e.res == '0);
    return e;
  endfunction

  // Monitor: checks latency on first sight of out_valid, fields on handshake.
  always @(negedge clk) begin
    if (rst) begin
      mon_seen = 1'b0;
    end else if (out_valid) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got result %h with empty scoreboard", result);
      end else begin
        if (!mon_seen) begin
          mon_seen = 1'b1;
          chk("latency", W'(cyc - q[0].acc_cyc + 1), W'(q[0].lat));
        end
        if (out_ready) begin
          exp_t e;
          e = q.pop_front();
          chk("result", result, e.res);
          chk("zero", W'(zero), W'(e.zero));
          chk("ovf", W'(ovf), W'(e.ovf));
          chk("illegal", W'(illegal), W'(e.ill));
          mon_seen = 1'b0;
        end
      end
    end
  end

  task automatic issue(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: in_ready %0b expected 1", in_ready);
      return;
    end
    alu_ctrl = c;
    op_a     = a;
    op_b     = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    op_a     = $urandom;
    op_b     = $urandom;
    e = model(c, a, b);
    e.acc_cyc = cyc;
    q.push_back(e);
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: %0d pending expected 0", q.size());
    end
  endtask

  initial begin
    logic [W-1:0] held;
    logic [3:0]   c;
    #23;
    chk("reset_out_valid", W'(out_valid), '0);
    chk("reset_result", result, '0);
    chk("reset_in_ready", W'(in_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;

    issue(4'd2, 32'h7FFF_FFFF, 32'h1);
    issue(4'd3, 32'd5, 32'd5);
    issue(4'd0, 32'h0000_F0F0, 32'h0000_0FF0);
    issue(4'd4, 32'd12, 32'd13);
    issue(4'd4, 32'hFFFF_FFFF, 32'd2);
    issue(4'hF, 32'h1234_5678, 32'h9ABC_DEF0);
    issue(4'd3, 32'h8000_0000, 32'd1);
    drain();

    // Backpressure: result held, busy, and new requests ignored.
    rand_rdy = 1'b0;
    #3 out_ready = 1'b0;
    issue(4'd1, 32'hA5A5_0000, 32'h0000_5A5A);
    @(negedge clk);
    held = result;
    chk("bp_result_first", held, 32'hA5A5_5A5A);
    alu_ctrl = 4'd2;
    op_a = 32'd1;
    op_b = 32'd1;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_in_ready", W'(in_ready), '0);
      chk("bp_out_valid", W'(out_valid), 32'd1);
      chk("bp_result_held", result, held);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    drain();
    @(negedge clk);
    chk("bp_ignored_idle", W'(out_valid), '0);
    rand_rdy = 1'b1;

    // Async reset mid-cycle while an output is waiting.
    rand_rdy = 1'b0;
    #3 out_ready = 1'b0;
    issue(4'd2, 32'd40, 32'd2);
    @(posedge clk);
    #3;
    rst = 1'b1;
    q.delete();
    #1;
    chk("arst_out_valid", W'(out_valid), '0);
    chk("arst_result", result, '0);
    chk("arst_in_ready", W'(in_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    rand_rdy = 1'b1;

    // Reset in the middle of a multiply (counter at 10).
    issue(4'd4, 32'd7, 32'd9);
    repeat (10) @(posedge clk);
    #3;
    rst = 1'b1;
    q.delete();
    #1;
    chk("mul_rst_in_ready", W'(in_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    begin
      int seen = 0;
      for (int i = 0; i < 40; i++) begin
        @(negedge clk);
        if (out_valid) seen++;
      end
      chk("mul_rst_no_output", W'(seen), '0);
    end

    for (int i = 0; i < 40; i++) begin
      c = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(5, 15)) : 4'($urandom_range(0, 4));
      case ($urandom_range(0, 3))
        0: issue(c, $urandom, $urandom);
        1: issue(c, 32'h7FFF_FFFF - $urandom_range(0, 3), $urandom_range(0, 3));
        2: issue(c, 32'h8000_0000 + $urandom_range(0, 3), $urandom_range(0, 3));
        default: issue(c, $urandom_range(0, 255), $urandom_range(0, 255));
      endcase
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
